// File: rtl/ram_lsu_master.sv
// Load/store initiator for a word-wide data RAM with a fixed read latency.
// Handles byte/half/word accesses, read-modify-write for sub-word stores and misalignment errors.
module ram_lsu_master #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        MemWrite,
    output logic [31:0] A,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_RESP} state_t;

    localparam logic [1:0] LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    state_t      state_reg, state_next;
    logic        we_reg, sign_reg, err_reg;
    logic [1:0]  size_reg, lane_reg, cnt_reg;
    logic [15:0] wdata_reg;
    logic        mem_write_reg, mem_write_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] write_data_reg, write_data_next;
    logic [31:0] rdata_reg, rdata_next;

    logic        misaligned, word_store, sample_now;
    logic [31:0] lane_data, merged, shifted, extended;
    logic [3:0]  byte_en;

    assign misaligned = (size == 2'b11) ||
                        (size == 2'b01 && addr[0]) ||
                        (size == 2'b10 && addr[1:0] != 2'b00);
    assign word_store = we_reg && (size_reg == 2'b10);

    // The cycle in which ReadData carries the addressed word.
    assign sample_now = (state_reg == S_ISSUE && !word_store && READ_LATENCY == 0) ||
                        (state_reg == S_WAIT && cnt_reg == LAT_LAST);

    // Sub-word store data replicated across lanes, then merged per byte.
    assign lane_data = (size_reg == 2'b00) ? {4{wdata_reg[7:0]}} : {2{wdata_reg[15:0]}};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_en[gi] = (size_reg == 2'b00) ? (lane_reg == 2'(gi))
                                                     : (lane_reg[1] == 1'(gi / 2));
            assign merged[8*gi +: 8] = byte_en[gi] ? lane_data[8*gi +: 8] : ReadData[8*gi +: 8];
        end
    endgenerate

    assign shifted = ReadData >> {lane_reg, 3'b000};

    always_comb begin
        case (size_reg)
            2'b00:   extended = {{24{sign_reg & shifted[7]}}, shifted[7:0]};
            2'b01:   extended = {{16{sign_reg & shifted[15]}}, shifted[15:0]};
            default: extended = ReadData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req) state_next = misaligned ? S_RESP : S_ISSUE;
            S_ISSUE: begin
                if (word_store)      state_next = S_RESP;
                else if (sample_now) state_next = we_reg ? S_WRITE : S_RESP;
                else                 state_next = S_WAIT;
            end
            S_WAIT:  if (sample_now) state_next = we_reg ? S_WRITE : S_RESP;
            S_WRITE: state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next values for the registered RAM-side outputs and the load result.
    always_comb begin
        mem_write_next  = 1'b0;
        a_next          = a_reg;
        write_data_next = write_data_reg;
        rdata_next      = rdata_reg;
        if (state_reg == S_IDLE && req && !misaligned) begin
            a_next = {addr[31:2], 2'b00};
            if (we && size == 2'b10) begin
                mem_write_next  = 1'b1;
                write_data_next = wdata;
            end
        end
        if (sample_now) begin
            if (we_reg) begin
                mem_write_next  = 1'b1;
                write_data_next = merged;
            end else begin
                rdata_next = extended;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg         <= 1'b0;
            sign_reg       <= 1'b0;
            err_reg        <= 1'b0;
            size_reg       <= 2'b00;
            lane_reg       <= 2'b00;
            cnt_reg        <= 2'b00;
            wdata_reg      <= '0;
            mem_write_reg  <= 1'b0;
            a_reg          <= '0;
            write_data_reg <= '0;
            rdata_reg      <= '0;
        end else begin
            if (state_reg == S_IDLE && req) begin
                we_reg    <= we;
                sign_reg  <= sign_ext;
                err_reg   <= misaligned;
                size_reg  <= size;
                lane_reg  <= addr[1:0];
                wdata_reg <= wdata[15:0];
            end
            cnt_reg        <= (state_reg == S_WAIT) ? cnt_reg + 2'd1 : 2'd0;
            mem_write_reg  <= mem_write_next;
            a_reg          <= a_next;
            write_data_reg <= write_data_next;
            rdata_reg      <= rdata_next;
        end
    end

    assign ready     = (state_reg == S_IDLE);
    assign done      = (state_reg == S_RESP);
    assign err       = (state_reg == S_RESP) && err_reg;
    assign rdata     = rdata_reg;
    assign MemWrite  = mem_write_reg;
    assign A         = a_reg;
    assign WriteData = write_data_reg;

endmodule

// File: tb/tb_ram_lsu_master.sv
// Directed checks of ram_lsu_master at read latencies 0, 1 and 3, each instance with its own RAM model.
module tb_ram_lsu_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_v, req_v, we_v, sx_v, ready_v, done_v, err_v, mw_v;
    logic [2:0][1:0]  size_v;
    logic [2:0][31:0] addr_v, wdata_v, rdata_v, a_v, wd_v, rd_v;

    logic [31:0] ram  [3][1024];
    logic [31:0] pipe [3][3];

    int tests  = 0;
    int failed = 0;

    int          r_done, r_mwc, r_mwat;
    logic [31:0] r_mwa, r_mwd, r_rd;
    logic        r_err;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;
            ram_lsu_master #(.READ_LATENCY(LAT)) u_dut (
                .clk(clk), .rst(rst_v[gi]), .req(req_v[gi]), .we(we_v[gi]),
                .size(size_v[gi]), .sign_ext(sx_v[gi]), .addr(addr_v[gi]),
                .wdata(wdata_v[gi]), .ready(ready_v[gi]), .done(done_v[gi]),
                .err(err_v[gi]), .rdata(rdata_v[gi]), .MemWrite(mw_v[gi]),
                .A(a_v[gi]), .WriteData(wd_v[gi]), .ReadData(rd_v[gi])
            );
            if (LAT == 0) begin : g_comb
                assign rd_v[gi] = ram[gi][a_v[gi][11:2]];
            end else begin : g_pipe
                assign rd_v[gi] = pipe[gi][LAT-1];
            end
        end
    endgenerate

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mw_v[k]) ram[k][a_v[k][11:2]] <= wd_v[k];
            pipe[k][0] <= ram[k][a_v[k][11:2]];
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on instance k and observe until done (bounded), starting #1 after an edge.
    task automatic xact(input int k, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] ad, input logic [31:0] wd);
        int n;
        check($sformatf("k%0d ready before req", k), 32'(ready_v[k]), 32'd1);
        req_v[k] = 1'b1; we_v[k] = w; size_v[k] = sz; sx_v[k] = sx;
        addr_v[k] = ad; wdata_v[k] = wd;
        @(posedge clk); #1;
        req_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = 32'hFFFF_FFFF; wdata_v[k] = 32'h5A5A_5A5A;
        r_done = -1; r_mwc = 0; r_mwat = -1; r_mwa = '0; r_mwd = '0; r_err = 1'b0; r_rd = '0;
        n = 1;
        while (n <= 12 && r_done < 0) begin
            if (mw_v[k]) begin
                r_mwc++; r_mwat = n; r_mwa = a_v[k]; r_mwd = wd_v[k];
            end
            if (done_v[k]) begin
                r_done = n; r_err = err_v[k]; r_rd = rdata_v[k];
            end
            @(posedge clk); #1;
            n++;
        end
        $display("[TB] k%0d we=%0d size=%0d sx=%0d addr=%h wdata=%h -> done@T+%0d err=%0d rdata=%h writes=%0d",
                 k, w, sz, sx, ad, wd, r_done, r_err, r_rd, r_mwc);
    endtask

    task automatic load(input int k, input int lat, input logic [1:0] sz, input logic sx,
                        input logic [31:0] ad, input logic [31:0] exp);
        xact(k, 1'b0, sz, sx, ad, 32'h0);
        check($sformatf("k%0d load %h done", k, ad), 32'(r_done), 32'(2 + lat));
        check($sformatf("k%0d load %h err", k, ad), 32'(r_err), 32'd0);
        check($sformatf("k%0d load %h rdata", k, ad), r_rd, exp);
        check($sformatf("k%0d load %h writes", k, ad), 32'(r_mwc), 32'd0);
    endtask

    task automatic wstore(input int k, input logic [31:0] ad, input logic [31:0] d);
        xact(k, 1'b1, 2'b10, 1'b0, ad, d);
        check($sformatf("k%0d wst %h done", k, ad), 32'(r_done), 32'd2);
        check($sformatf("k%0d wst %h writes", k, ad), 32'(r_mwc), 32'd1);
        check($sformatf("k%0d wst %h write at", k, ad), 32'(r_mwat), 32'd1);
        check($sformatf("k%0d wst %h A", k, ad), r_mwa, ad);
        check($sformatf("k%0d wst %h data", k, ad), r_mwd, d);
        check($sformatf("k%0d wst %h err", k, ad), 32'(r_err), 32'd0);
    endtask

    task automatic substore(input int k, input int lat, input logic [1:0] sz, input logic [31:0] ad,
                            input logic [31:0] d, input logic [31:0] exp_word, input logic [31:0] old_rd);
        xact(k, 1'b1, sz, 1'b0, ad, d);
        check($sformatf("k%0d sst %h done", k, ad), 32'(r_done), 32'(3 + lat));
        check($sformatf("k%0d sst %h writes", k, ad), 32'(r_mwc), 32'd1);
        check($sformatf("k%0d sst %h write at", k, ad), 32'(r_mwat), 32'(2 + lat));
        check($sformatf("k%0d sst %h A", k, ad), r_mwa, {ad[31:2], 2'b00});
        check($sformatf("k%0d sst %h data", k, ad), r_mwd, exp_word);
        check($sformatf("k%0d sst %h rdata kept", k, ad), r_rd, old_rd);
    endtask

    task automatic bad(input int k, input logic w, input logic [1:0] sz, input logic [31:0] ad,
                       input logic [31:0] old_rd);
        xact(k, w, sz, 1'b1, ad, 32'hDEAD_BEEF);
        check($sformatf("k%0d bad %h done", k, ad), 32'(r_done), 32'd1);
        check($sformatf("k%0d bad %h err", k, ad), 32'(r_err), 32'd1);
        check($sformatf("k%0d bad %h writes", k, ad), 32'(r_mwc), 32'd0);
        check($sformatf("k%0d bad %h rdata kept", k, ad), r_rd, old_rd);
    endtask

    task automatic reset_in_wait(input int k);
        int seen;
        seen = 0;
        req_v[k] = 1'b1; we_v[k] = 1'b1; size_v[k] = 2'b00; addr_v[k] = 32'h1000; wdata_v[k] = 32'h77;
        @(posedge clk); #1;
        req_v[k] = 1'b0;
        seen += int'(mw_v[k]) + int'(done_v[k]);
        @(posedge clk); #1;
        seen += int'(mw_v[k]) + int'(done_v[k]);
        rst_v[k] = 1'b1;
        @(posedge clk); #1;
        rst_v[k] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen += int'(mw_v[k]) + int'(done_v[k]);
            @(posedge clk); #1;
        end
        $display("[TB] k%0d reset during byte-store wait, write/done pulses seen=%0d", k, seen);
        check($sformatf("k%0d rst pulses", k), 32'(seen), 32'd0);
        check($sformatf("k%0d rst ready", k), 32'(ready_v[k]), 32'd1);
        check($sformatf("k%0d rst A", k), a_v[k], 32'h0);
        check($sformatf("k%0d rst rdata", k), rdata_v[k], 32'h0);
    endtask

    task automatic suite(input int k);
        int lat;
        lat = (k == 0) ? 0 : (k == 1) ? 1 : 3;
        wstore(k, 32'h1000, 32'h0000_13FF);
        load(k, lat, 2'b10, 1'b0, 32'h1000, 32'h0000_13FF);
        wstore(k, 32'h1004, 32'h1122_3344);
        substore(k, lat, 2'b00, 32'h1006, 32'h0000_00AB, 32'h11AB_3344, 32'h0000_13FF);
        load(k, lat, 2'b10, 1'b0, 32'h1004, 32'h11AB_3344);
        wstore(k, 32'h1004, 32'h80F0_7F01);
        load(k, lat, 2'b00, 1'b1, 32'h1006, 32'hFFFF_FFF0);
        load(k, lat, 2'b00, 1'b0, 32'h1006, 32'h0000_00F0);
        load(k, lat, 2'b01, 1'b1, 32'h1006, 32'hFFFF_80F0);
        load(k, lat, 2'b00, 1'b1, 32'h1005, 32'h0000_007F);
        bad(k, 1'b1, 2'b10, 32'h1002, 32'h0000_007F);
        bad(k, 1'b0, 2'b01, 32'h1001, 32'h0000_007F);
        bad(k, 1'b1, 2'b11, 32'h1000, 32'h0000_007F);
        load(k, lat, 2'b10, 1'b0, 32'h1000, 32'h0000_13FF);
        substore(k, lat, 2'b01, 32'h1006, 32'h1234_BEEF, 32'hBEEF_7F01, 32'h0000_13FF);
        load(k, lat, 2'b10, 1'b0, 32'h1004, 32'hBEEF_7F01);
        if (lat > 0) begin
            reset_in_wait(k);
            load(k, lat, 2'b10, 1'b0, 32'h1000, 32'h0000_13FF);
        end
    endtask

    initial begin
        rst_v = '1; req_v = '0; we_v = '0; sx_v = '0; size_v = '0; addr_v = '0; wdata_v = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_v = '0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("k%0d reset ready", k), 32'(ready_v[k]), 32'd1);
            check($sformatf("k%0d reset done", k), 32'(done_v[k]), 32'd0);
            check($sformatf("k%0d reset err", k), 32'(err_v[k]), 32'd0);
            check($sformatf("k%0d reset rdata", k), rdata_v[k], 32'h0);
            check($sformatf("k%0d reset MemWrite", k), 32'(mw_v[k]), 32'd0);
            check($sformatf("k%0d reset A", k), a_v[k], 32'h0);
            check($sformatf("k%0d reset WriteData", k), wd_v[k], 32'h0);
        end
        for (int k = 0; k < 3; k++) suite(k);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
